mem_stage: RTL and testbench

Memory-access stage of the RV32IM pipeline, directly downstream of the execute stage. It takes the execute stage's ALU result as the effective address, performs byte/half/word loads and stores over a req/ready data-memory port, and stalls upstream while a transaction is outstanding. It drives the registered MEM/WB outputs, with load sign/zero extension and exception codes.

---
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the memory-access stage.
// The stage is the master; the data memory (or its model) is the slave.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mem_stage.sv
// RV32IM memory-access stage: byte/half/word loads and stores over a req/ready
// port, upstream stall while a transaction is open, registered MEM/WB outputs.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               RegWrite,
  input  logic [2:0]         funct3,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        rs2_data,
  input  logic [4:0]         rd,
  output logic               stall,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic               wb_RegWrite,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic [1:0]         wb_exc
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [2:0]  f3_p1;
  logic [1:0]  alo_p1;
  logic        rw_p1;
  logic        load_p1;
  logic [4:0]  rd_p1;
  logic        mem_op, illegal, misal, stall_raw;
  logic        accept, done_ok, done_to;
  logic [1:0]  exc_p0;

  function automatic logic [31:0] load_extract(input logic [31:0] data,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(data >> {lo, 3'b000});
    h = 16'(data >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h0, b};
      3'b101:  load_extract = {16'h0, h};
      default: load_extract = data;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic       is_load,
                                            input logic [2:0] f3,
                                            input logic [1:0] lo);
    if (is_load)            store_strb = 4'b0000;
    else if (f3 == 3'b000)  store_strb = 4'b0001 << lo;
    else if (f3 == 3'b001)  store_strb = 4'b0011 << {lo[1], 1'b0};
    else                    store_strb = 4'b1111;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                              input logic [31:0] src);
    case (f3)
      3'b000:  store_wdata = {4{src[7:0]}};
      3'b001:  store_wdata = {2{src[15:0]}};
      default: store_wdata = src;
    endcase
  endfunction

  // Stage 0: classify the presented op; MemRead wins over MemWrite
  assign mem_op = in_valid & (MemRead | MemWrite);

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    if (MemRead) illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else         illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    if (funct3[1:0] == 2'b01)      misal = alu_result[0];
    else if (funct3[1:0] == 2'b10) misal = (alu_result[1:0] != 2'b00);
    if (illegal)    exc_p0 = 2'b11;
    else if (misal) exc_p0 = 2'b01;
    else            exc_p0 = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && exc_p0 == 2'b00) begin
          accept    = 1'b1;
          stall_raw = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem.ready) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt >= TIMEOUT_LIM) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While reset is held the inputs are ignored, so stall must read low too
  assign stall = stall_raw & rst_n;

  // Stage 1: request registers, latched op context and MEM/WB outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'h00;
      f3_p1       <= 3'b000;
      alo_p1      <= 2'b00;
      rw_p1       <= 1'b0;
      load_p1     <= 1'b0;
      rd_p1       <= 5'd0;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= 32'h0;
      dmem.wdata  <= 32'h0;
      dmem.wstrb  <= 4'b0000;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'h0;
      wb_exc      <= 2'b00;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          f3_p1      <= funct3;
          alo_p1     <= alu_result[1:0];
          rw_p1      <= RegWrite;
          load_p1    <= MemRead;
          rd_p1      <= rd;
          cnt        <= 8'h00;
          dmem.req   <= 1'b1;
          dmem.we    <= ~MemRead;
          dmem.addr  <= {alu_result[31:2], 2'b00};
          dmem.wdata <= store_wdata(funct3, rs2_data);
          dmem.wstrb <= store_strb(MemRead, funct3, alu_result[1:0]);
        end else if (mem_op) begin
          wb_valid    <= 1'b1;
          wb_RegWrite <= 1'b0;
          wb_rd       <= rd;
          wb_data     <= 32'h0;
          wb_exc      <= exc_p0;
        end else begin
          wb_valid    <= in_valid;
          wb_RegWrite <= RegWrite;
          wb_rd       <= rd;
          wb_data     <= alu_result;
          wb_exc      <= 2'b00;
        end
      end else if (done_ok) begin
        dmem.req    <= 1'b0;
        wb_valid    <= 1'b1;
        wb_RegWrite <= load_p1 & rw_p1;
        wb_rd       <= rd_p1;
        wb_data     <= load_p1 ? load_extract(dmem.rdata, f3_p1, alo_p1) : 32'h0;
        wb_exc      <= 2'b00;
      end else if (done_to) begin
        dmem.req    <= 1'b0;
        wb_valid    <= 1'b1;
        wb_RegWrite <= 1'b0;
        wb_rd       <= rd_p1;
        wb_data     <= 32'h0;
        wb_exc      <= 2'b10;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the load/store rules.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, MemRead, MemWrite, RegWrite;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd;
  logic        stall, wb_valid, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc;

  int errors = 0;
  int checks = 0;

  mem_stage_if dmem();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .funct3(funct3),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd), .stall(stall),
    .dmem(dmem), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  always #5 clk = ~clk;

  // Observations recorded by run_op
  int          o_stall_cnt, o_wbv_cnt, o_wb_cycle, o_cons;
  logic [31:0] o_req_mask;
  logic        o_wb_rw, o_we, o_stable;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_addr, o_wdata;
  logic [1:0]  o_wb_exc;
  logic [3:0]  o_wstrb;

  task automatic idle_inputs();
    in_valid = 0; MemRead = 0; MemWrite = 0; RegWrite = 0;
    funct3 = 0; alu_result = 0; rs2_data = 0; rd = 0;
  endtask

  task automatic present(input logic v, mr, mw, rw, input logic [2:0] f3,
                         input logic [31:0] a, rs2, input logic [4:0] r);
    in_valid = v; MemRead = mr; MemWrite = mw; RegWrite = rw;
    funct3 = f3; alu_result = a; rs2_data = rs2; rd = r;
  endtask

  // Presents one op at cycle 0, holds it while stalled, ready only in cycle lat.
  task automatic run_op(input logic v, mr, mw, rw, input logic [2:0] f3,
                        input logic [31:0] a, rs2, input logic [4:0] r,
                        input int lat, input logic [31:0] rdat);
    o_stall_cnt = 0; o_wbv_cnt = 0; o_wb_cycle = -1; o_cons = -1;
    o_req_mask = 0; o_stable = 1; o_wb_rw = 0; o_wb_rd = 0; o_wb_data = 0;
    o_wb_exc = 0; o_addr = 0; o_we = 0; o_wdata = 0; o_wstrb = 0;
    present(v, mr, mw, rw, f3, a, rs2, r);
    for (int c = 0; c < 20; c++) begin
      if (o_cons >= 0 && c == o_cons + 1) idle_inputs();
      dmem.ready = (c == lat);
      dmem.rdata = (c == lat) ? rdat : $urandom;
      #1;
      if (wb_valid) begin
        o_wbv_cnt++;
        if (o_wbv_cnt == 1) begin
          o_wb_cycle = c; o_wb_rw = wb_RegWrite; o_wb_rd = wb_rd;
          o_wb_data = wb_data; o_wb_exc = wb_exc;
        end
      end
      if (dmem.req) begin
        if (o_req_mask == 0) begin
          o_addr = dmem.addr; o_we = dmem.we; o_wdata = dmem.wdata; o_wstrb = dmem.wstrb;
        end else if (dmem.addr !== o_addr || dmem.we !== o_we ||
                     dmem.wdata !== o_wdata || dmem.wstrb !== o_wstrb) begin
          o_stable = 0;
        end
        o_req_mask[c] = 1'b1;
      end
      if (o_cons < 0) begin
        if (stall) o_stall_cnt++;
        else o_cons = c;
      end
      @(posedge clk); #1;
      if (o_cons >= 0 && c >= o_cons + 2) break;
    end
    dmem.ready = 0;
  endtask

  // Reference model: expected outcome of a single op with ready in cycle lat.
  function automatic void model(input logic v, mr, mw, rw, input logic [2:0] f3,
                                input logic [31:0] a, rs2, rdat, input int lat,
                                output int e_vcnt, output int e_k, output logic e_req,
                                output logic [1:0] e_exc, output logic [31:0] e_data,
                                output logic e_rw, output logic [3:0] e_strb,
                                output logic [31:0] e_wdata);
    int unsigned size, val;
    bit legal;
    e_vcnt = v ? 1 : 0; e_k = 0; e_req = 0; e_exc = 0; e_data = a; e_rw = rw;
    e_strb = 0; e_wdata = 0;
    if (!(v && (mr || mw))) return;
    size  = f3 % 4;
    legal = mr ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    e_rw = 0; e_data = 0;
    if (!legal) begin e_exc = 2'b11; return; end
    if ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0)) begin
      e_exc = 2'b01; return;
    end
    e_req = 1;
    if (!mr) begin
      if (size == 0)      begin e_strb = 4'(1 << (a % 4)); e_wdata = rs2[7:0] * 32'h01010101; end
      else if (size == 1) begin e_strb = 4'(3 << (a & 2));  e_wdata = rs2[15:0] * 32'h00010001; end
      else                begin e_strb = 4'hF;              e_wdata = rs2; end
    end
    if (lat > TO + 1) begin e_k = TO + 1; e_exc = 2'b10; return; end
    e_k = lat;
    if (mr) begin
      e_rw = rw;
      if (size == 0) begin
        val = (rdat >> (8 * (a % 4))) % 256;
        if (f3 < 4 && val >= 128) val = val + 32'hFFFFFF00;
      end else if (size == 1) begin
        val = (rdat >> (16 * ((a / 2) % 2))) % 65536;
        if (f3 < 4 && val >= 32768) val = val + 32'hFFFF0000;
      end else begin
        val = rdat;
      end
      e_data = val;
    end
  endfunction

  task automatic test_reset();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++;
    if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.wstrb} !== 70'h0) begin
      errors++; $display("FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h wstrb=%b want all 0",
                         dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.wstrb);
    end
    checks++;
    if ({wb_valid, wb_RegWrite, wb_rd, wb_data, wb_exc} !== 41'h0) begin
      errors++; $display("FAIL reset_wb got v=%b rw=%b rd=%0d data=%h exc=%b want all 0",
                         wb_valid, wb_RegWrite, wb_rd, wb_data, wb_exc);
    end
  endtask

  task automatic test_load_byte();
    run_op(1, 1, 0, 1, 3'b000, 32'h103, 32'h0, 5'd7, 1, 32'h80FF1234);
    checks++; if (o_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_wstrb got %b want 0000", o_wstrb); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h want 00000100", o_addr); end
    checks++; if (o_wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", o_wb_data); end
    checks++; if (o_wb_cycle !== 2) begin errors++; $display("FAIL lb_wb_cycle got %0d want 2", o_wb_cycle); end
    checks++; if (o_stall_cnt !== 1) begin errors++; $display("FAIL lb_stalls got %0d want 1", o_stall_cnt); end
    checks++; if (o_wb_rw !== 1'b1 || o_wb_rd !== 5'd7) begin
      errors++; $display("FAIL lb_rw_rd got rw=%b rd=%0d want rw=1 rd=7", o_wb_rw, o_wb_rd); end
    run_op(1, 1, 0, 1, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h80FF1234);
    checks++; if (o_wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h want 00000080", o_wb_data); end
  endtask

  task automatic test_store_half();
    run_op(1, 0, 1, 1, 3'b001, 32'h202, 32'hDEADBEEF, 5'd3, 3, 32'h0);
    checks++; if (o_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", o_wdata); end
    checks++; if (o_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b want 1100", o_wstrb); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", o_we); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", o_stable); end
    checks++; if (o_stall_cnt !== 3 || o_cons !== 3) begin
      errors++; $display("FAIL sh_stall got stalls=%0d release=%0d want 3/3", o_stall_cnt, o_cons); end
    checks++; if (o_wb_rw !== 1'b0 || o_wbv_cnt !== 1) begin
      errors++; $display("FAIL sh_wb got rw=%b count=%0d want rw=0 count=1", o_wb_rw, o_wbv_cnt); end
  endtask

  task automatic test_exceptions();
    run_op(1, 1, 0, 1, 3'b010, 32'h006, 32'h0, 5'd9, 1, 32'h0);
    checks++; if (o_req_mask !== 0 || o_stall_cnt !== 0) begin
      errors++; $display("FAIL misal_noreq got mask=%h stalls=%0d want 0/0", o_req_mask, o_stall_cnt); end
    checks++; if (o_wb_cycle !== 1 || o_wb_exc !== 2'b01 || o_wb_rw !== 1'b0) begin
      errors++; $display("FAIL misal_wb got cyc=%0d exc=%b rw=%b want 1/01/0", o_wb_cycle, o_wb_exc, o_wb_rw); end
    run_op(1, 1, 0, 1, 3'b011, 32'h010, 32'h0, 5'd9, 1, 32'h0);
    checks++; if (o_wb_exc !== 2'b11 || o_req_mask !== 0) begin
      errors++; $display("FAIL illegal_ld got exc=%b mask=%h want 11/0", o_wb_exc, o_req_mask); end
    run_op(1, 0, 1, 0, 3'b100, 32'h010, 32'h0, 5'd9, 1, 32'h0);
    checks++; if (o_wb_exc !== 2'b11) begin errors++; $display("FAIL illegal_st got exc=%b want 11", o_wb_exc); end
  endtask

  task automatic test_timeout();
    run_op(1, 1, 0, 1, 3'b010, 32'h040, 32'h0, 5'd4, 99, 32'h0);
    checks++; if (o_req_mask[4:0] !== 5'b11110) begin
      errors++; $display("FAIL to_req got mask=%b want 11110", o_req_mask[4:0]); end
    checks++; if (o_cons !== TO + 1 || o_stall_cnt !== TO + 1) begin
      errors++; $display("FAIL to_release got release=%0d stalls=%0d want 5/5", o_cons, o_stall_cnt); end
    checks++; if (o_wb_cycle !== TO + 2 || o_wb_exc !== 2'b10 || o_wb_rw !== 1'b0) begin
      errors++; $display("FAIL to_wb got cyc=%0d exc=%b rw=%b want 6/10/0", o_wb_cycle, o_wb_exc, o_wb_rw); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3] = '{32'h1234, 32'hCAFEF00D, 32'h0};
    logic        exp_rw[3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0]  exp_rd[3] = '{5'd5, 5'd6, 5'd7};
    int idx = 0, nwb = 0, nreq = 0, last_cons = -1;
    dmem.ready = 1; dmem.rdata = 32'hCAFEF00D;
    present(1, 0, 0, 1, 3'b000, 32'h1234, 32'h0, 5'd5);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (wb_valid) begin
        if (nwb < 3) begin
          checks++;
          if (wb_data !== exp_d[nwb] || wb_RegWrite !== exp_rw[nwb] || wb_rd !== exp_rd[nwb] || wb_exc !== 2'b00) begin
            errors++; $display("FAIL b2b_wb%0d got data=%h rw=%b rd=%0d exc=%b want data=%h rw=%b rd=%0d exc=00",
                               nwb, wb_data, wb_RegWrite, wb_rd, wb_exc, exp_d[nwb], exp_rw[nwb], exp_rd[nwb]);
          end
        end
        nwb++;
      end
      if (dmem.req) nreq++;
      if (idx < 3 && !stall) begin idx++; last_cons = c; end
      @(posedge clk); #1;
      if (idx == 1)      present(1, 1, 0, 1, 3'b010, 32'h10, 32'h0, 5'd6);
      else if (idx == 2) present(1, 0, 1, 0, 3'b010, 32'h14, 32'h11223344, 5'd7);
      else               idle_inputs();
    end
    dmem.ready = 0;
    checks++; if (nwb !== 3) begin errors++; $display("FAIL b2b_wb_count got %0d want 3", nwb); end
    checks++; if (nreq !== 2) begin errors++; $display("FAIL b2b_req_cycles got %0d want 2", nreq); end
    checks++; if (last_cons !== 4) begin errors++; $display("FAIL b2b_last_accept got %0d want 4", last_cons); end
  endtask

  task automatic test_reset_mid_wait();
    dmem.ready = 0;
    present(1, 1, 0, 1, 3'b010, 32'h20, 32'h0, 5'd2);
    repeat (2) begin @(posedge clk); #1; end
    #1;
    checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL rstw_pre_req got %b want 1", dmem.req); end
    #2 rst_n = 0;
    #1;
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_drop got req=%b stall=%b wbv=%b want 0/0/0", dmem.req, stall, wb_valid); end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_wb got %b want 0", wb_valid); end
    run_op(1, 1, 0, 1, 3'b010, 32'h30, 32'h0, 5'd8, 2, 32'h5555AAAA);
    checks++; if (o_wb_data !== 32'h5555AAAA || o_wb_exc !== 2'b00 || o_wb_cycle !== 3 || o_wbv_cnt !== 1) begin
      errors++; $display("FAIL rstw_after got data=%h exc=%b cyc=%0d n=%0d want 5555aaaa/00/3/1",
                         o_wb_data, o_wb_exc, o_wb_cycle, o_wbv_cnt); end
  endtask

  task automatic test_random();
    logic v, mr, mw, rw, e_req, e_rw;
    logic [2:0] f3;
    logic [31:0] a, rs2, rdat, e_data, e_wdata;
    logic [4:0] r;
    logic [1:0] e_exc;
    logic [3:0] e_strb;
    int lat, e_vcnt, e_k;
    for (int n = 0; n < 60; n++) begin
      v = ($urandom % 8) != 0;
      mr = ($urandom % 3) == 0; mw = ($urandom % 2) == 0; rw = $urandom;
      f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
      a = $urandom; rs2 = $urandom; rdat = $urandom; r = 5'($urandom);
      if ($urandom % 2) a[1:0] = 2'b00;
      lat = 1 + $urandom % 7;
      run_op(v, mr, mw, rw, f3, a, rs2, r, lat, rdat);
      model(v, mr, mw, rw, f3, a, rs2, rdat, lat, e_vcnt, e_k, e_req, e_exc, e_data, e_rw, e_strb, e_wdata);
      checks++; if (o_cons !== e_k || o_stall_cnt !== e_k) begin
        errors++; $display("FAIL rnd%0d_stall got release=%0d stalls=%0d want %0d", n, o_cons, o_stall_cnt, e_k); end
      checks++; if (o_wbv_cnt !== e_vcnt) begin
        errors++; $display("FAIL rnd%0d_wb_count got %0d want %0d", n, o_wbv_cnt, e_vcnt); end
      if (e_vcnt == 1) begin
        checks++; if (o_wb_cycle !== e_k + 1 || o_wb_exc !== e_exc || o_wb_rw !== e_rw || o_wb_rd !== r) begin
          errors++; $display("FAIL rnd%0d_wb got cyc=%0d exc=%b rw=%b rd=%0d want %0d/%b/%b/%0d",
                             n, o_wb_cycle, o_wb_exc, o_wb_rw, o_wb_rd, e_k + 1, e_exc, e_rw, r); end
        if (e_exc != 2'b10) begin
          checks++; if (o_wb_data !== e_data) begin
            errors++; $display("FAIL rnd%0d_data got %h want %h", n, o_wb_data, e_data); end
        end
      end
      checks++; if ((o_req_mask != 0) !== e_req) begin
        errors++; $display("FAIL rnd%0d_req got mask=%h want req=%b", n, o_req_mask, e_req); end
      if (e_req) begin
        checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== !mr || o_wstrb !== e_strb || o_stable !== 1'b1 ||
            (!mr && o_wdata !== e_wdata)) begin
          errors++; $display("FAIL rnd%0d_bus got addr=%h we=%b strb=%b wdata=%h stable=%b want %h/%b/%b/%h/1",
                             n, o_addr, o_we, o_wstrb, o_wdata, o_stable, {a[31:2], 2'b00}, !mr, e_strb, e_wdata); end
      end
    end
  endtask

  initial begin
    dmem.ready = 0; dmem.rdata = 0;
    rst_n = 0;
    present(1, 1, 0, 1, 3'b010, 32'h0, 32'h0, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    idle_inputs();
    rst_n = 1;
    @(posedge clk); #1;
    test_load_byte();
    test_store_half();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
